// File: rtl/phase_seq_arbiter_pkg.sv
// Shared definitions for the phase sequencer arbiter: FSM state encoding and
// phase register geometry.
package phase_seq_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARB     = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam int             PHASE_W    = 2;
  localparam logic [PHASE_W-1:0] PHASE_LAST = 2'd3;

endpackage

// File: rtl/phase_seq_arbiter_if.sv
// Requester-side bus of the phase sequencer arbiter.
//   req   : level request, one bit per requester
//   rel   : release pulse, only the holder's bit matters
//   step  : phase-advance pulse
//   lock  : blocks new grants
//   gnt   : one-hot registered grant
//   phase : current sequencer phase
//   busy  : arbiter not idle
//   err   : one-cycle pulse on hold timeout / illegal state recovery
// master = requesting agents, slave = arbiter.
interface phase_seq_arbiter_if
  import phase_seq_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] rel;
  logic               step;
  logic               lock;
  logic [NUM_REQ-1:0] gnt;
  logic [PHASE_W-1:0] phase;
  logic               busy;
  logic               err;

  modport master (output req, rel, step, lock, input gnt, phase, busy, err);
  modport slave  (input req, rel, step, lock, output gnt, phase, busy, err);
endinterface

// File: rtl/phase_seq_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr,
// wrapping from NUM_REQ-1 back to 0.
//   req    : request vector
//   ptr    : highest-priority index this round
//   onehot : winner as one-hot (all zero if no request)
//   idx    : winner index (0 if no request)
module phase_seq_arbiter_rr_pick
  import phase_seq_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  int   cand;
  logic found;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        found                 = 1'b1;
        idx                   = IDX_W'(cand);
        onehot[IDX_W'(cand)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phase_seq_arbiter.sv
// Shares the 4-phase sequencer between NUM_REQ requesters with round-robin
// arbitration. Only the grant holder may advance the phase; a grant is
// force-released after HOLD_MAX cycles.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of phase_seq_arbiter_if (req/rel/step/lock in,
//           gnt/phase/busy/err out)
//
// state   | meaning
// IDLE    | no grant, waiting for a request while unlocked
// ARB     | one cycle, round-robin winner selected
// GRANT   | winner holds gnt, may step the phase
// RELEASE | one cycle, gnt low, pointer moves past the winner
module phase_seq_arbiter
  import phase_seq_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  phase_seq_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(HOLD_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);

  state_t             state;
  logic [NUM_REQ-1:0] gnt_q;
  logic               err_q;
  logic [PHASE_W-1:0] phase_q;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [CNT_W-1:0]   hold_cnt;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               want_grant;

  phase_seq_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (bus.req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign want_grant = (|bus.req) && !bus.lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gnt_q    <= '0;
      err_q    <= 1'b0;
      phase_q  <= '0;
      rr_ptr   <= '0;
      win_idx  <= '0;
      hold_cnt <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          gnt_q <= '0;
          if (want_grant) state <= ST_ARB;
        end
        ST_ARB: begin
          // Requests or lock are re-checked here; a drop aborts silently.
          if (want_grant) begin
            state    <= ST_GRANT;
            gnt_q    <= pick_onehot;
            win_idx  <= pick_idx;
            hold_cnt <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          // Step is honoured even in the cycle the grant ends.
          if (bus.step)
            phase_q <= (phase_q == PHASE_LAST) ? '0 : phase_q + PHASE_W'(1);
          if (bus.rel[win_idx] || !bus.req[win_idx]) begin
            state <= ST_RELEASE;
            gnt_q <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state <= ST_RELEASE;
            gnt_q <= '0;
            err_q <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          state    <= ST_IDLE;
          gnt_q    <= '0;
          hold_cnt <= '0;
          rr_ptr   <= (win_idx == IDX_LAST) ? '0 : win_idx + IDX_W'(1);
        end
        default: begin
          // Corrupted state register: drop the grant, keep phase, flag it.
          state <= ST_IDLE;
          gnt_q <= '0;
          err_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.err   = err_q;
  assign bus.phase = phase_q;
  assign bus.busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_phase_seq_arbiter.sv
module tb_phase_seq_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int HOLD_MAX = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  phase_seq_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  phase_seq_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] rl, input logic s, input logic l);
    bus.req  = r;
    bus.rel  = rl;
    bus.step = s;
    bus.lock = l;
  endtask

  task automatic do_reset();
    drive(4'b0, 4'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    drive(4'b0, 4'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.gnt !== 4'b0 || bus.phase !== 2'd0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold gnt=%b phase=%0d busy=%b err=%b expected 0 0 0 0",
               bus.gnt, bus.phase, bus.busy, bus.err);
    end
    rst_n = 1'b1;
    repeat (5) tick();
    checks++;
    if (bus.gnt !== 4'b0 || bus.phase !== 2'd0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle gnt=%b phase=%0d busy=%b err=%b expected 0 0 0 0",
               bus.gnt, bus.phase, bus.busy, bus.err);
    end
  endtask

  task automatic test_single();
    logic [1:0] exp_ph;
    do_reset();
    drive(4'b0010, 4'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.gnt !== 4'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_arb gnt=%b busy=%b expected 0000 1", bus.gnt, bus.busy);
    end
    tick();
    checks++;
    if (bus.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL single_latency gnt=%b expected 0010", bus.gnt);
    end
    for (int i = 1; i <= 4; i++) begin
      bus.step = 1'b1;
      tick();
      exp_ph = 2'(i % 4);
      checks++;
      if (bus.phase !== exp_ph) begin
        errors++;
        $display("FAIL single_step%0d phase=%0d expected %0d", i, bus.phase, exp_ph);
      end
    end
    bus.step = 1'b0;
    bus.rel  = 4'b0010;
    tick();
    checks++;
    if (bus.gnt !== 4'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_rel gnt=%b busy=%b expected 0000 1", bus.gnt, bus.busy);
    end
    bus.rel = 4'b0;
    bus.req = 4'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.phase !== 2'd0) begin
      errors++;
      $display("FAIL single_idle busy=%b phase=%0d expected 0 0", bus.busy, bus.phase);
    end
  endtask

  task automatic test_fairness();
    int order[$];
    int idle_run;
    int budget;
    int who;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    drive(4'b1111, 4'b0, 1'b0, 1'b0);
    idle_run = 0;
    budget   = 0;
    while (order.size() < 5 && budget < 100) begin
      tick();
      budget++;
      bus.rel = 4'b0;
      if (bus.gnt != 4'b0) begin
        who = -1;
        for (int b = 0; b < 4; b++) if (bus.gnt[b]) who = b;
        checks++;
        if (!$onehot(bus.gnt)) begin
          errors++;
          $display("FAIL fair_onehot gnt=%b expected one-hot", bus.gnt);
        end
        if (order.size() > 0) begin
          checks++;
          if (idle_run != 3) begin
            errors++;
            $display("FAIL fair_gap idle_cycles=%0d expected 3", idle_run);
          end
        end
        order.push_back(who);
        idle_run = 0;
        bus.rel  = bus.gnt;
      end else begin
        idle_run++;
      end
    end
    checks++;
    if (order.size() != 5) begin
      errors++;
      $display("FAIL fair_timeout grants=%0d expected 5", order.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (order[k] != exp_order[k]) begin
          errors++;
          $display("FAIL fair_order%0d got=%0d expected %0d", k, order[k], exp_order[k]);
        end
      end
    end
    drive(4'b0, 4'b0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    int wcnt;
    int held;
    int errs;
    logic err_first;
    do_reset();
    drive(4'b0100, 4'b0, 1'b0, 1'b0);
    wcnt = 0;
    while (bus.gnt == 4'b0 && wcnt < 10) begin
      tick();
      wcnt++;
    end
    checks++;
    if (bus.gnt !== 4'b0100) begin
      errors++;
      $display("FAIL to_grant gnt=%b expected 0100", bus.gnt);
    end
    held = 0;
    errs = 0;
    while (bus.gnt != 4'b0 && held < 30) begin
      if (bus.err) errs++;
      tick();
      held++;
    end
    err_first = bus.err;
    if (bus.err) errs++;
    bus.req = 4'b0;
    tick();
    if (bus.err) errs++;
    checks++;
    if (held != HOLD_MAX) begin
      errors++;
      $display("FAIL to_hold cycles=%0d expected %0d", held, HOLD_MAX);
    end
    checks++;
    if (errs != 1 || err_first !== 1'b1) begin
      errors++;
      $display("FAIL to_err pulses=%0d at_release=%b expected 1 1", errs, err_first);
    end
    repeat (3) tick();
  endtask

  task automatic test_lock();
    bit seen;
    do_reset();
    drive(4'b0001, 4'b0, 1'b0, 1'b1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.gnt != 4'b0 || bus.busy) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL lock_block grant_or_busy_seen=1 expected 0");
    end
    bus.lock = 1'b0;
    tick();
    checks++;
    if (bus.gnt !== 4'b0) begin
      errors++;
      $display("FAIL lock_arb gnt=%b expected 0000", bus.gnt);
    end
    tick();
    checks++;
    if (bus.gnt !== 4'b0001) begin
      errors++;
      $display("FAIL lock_grant gnt=%b expected 0001", bus.gnt);
    end
    bus.lock = 1'b1;
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    tick();
    checks++;
    if (bus.gnt !== 4'b0001 || bus.phase !== 2'd1) begin
      errors++;
      $display("FAIL lock_in_grant gnt=%b phase=%0d expected 0001 1", bus.gnt, bus.phase);
    end
    drive(4'b0, 4'b0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  task automatic test_abuse();
    do_reset();
    drive(4'b0, 4'b0, 1'b1, 1'b0);
    repeat (3) tick();
    checks++;
    if (bus.phase !== 2'd0 || bus.gnt !== 4'b0) begin
      errors++;
      $display("FAIL abuse_step phase=%0d gnt=%b expected 0 0000", bus.phase, bus.gnt);
    end
    drive(4'b0001, 4'b0, 1'b0, 1'b0);
    repeat (2) tick();
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    bus.rel  = 4'b0100;
    tick();
    bus.rel = 4'b0;
    tick();
    checks++;
    if (bus.gnt !== 4'b0001 || bus.phase !== 2'd1) begin
      errors++;
      $display("FAIL abuse_rel gnt=%b phase=%0d expected 0001 1", bus.gnt, bus.phase);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.gnt !== 4'b0 || bus.phase !== 2'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abuse_async_rst gnt=%b phase=%0d busy=%b expected 0000 0 0",
               bus.gnt, bus.phase, bus.busy);
    end
    tick();
    rst_n = 1'b1;
    drive(4'b0, 4'b0, 1'b0, 1'b0);
    tick();
  endtask

  // Reference: tracks who owns the sequencer and how long, plus the two
  // one-cycle gaps (arbitration, cool-down) as flags.
  task automatic test_random();
    int owner, age, ptr, ph, cand;
    bit arb, cool, exp_err, exp_busy;
    logic [3:0] r, rl, exp_gnt;
    logic s, l;
    do_reset();
    owner = -1; age = 0; ptr = 0; ph = 0; arb = 0; cool = 0; r = 4'b0;
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) r[b] = ~r[b];
      rl = 4'b0;
      for (int b = 0; b < 4; b++) if ($urandom_range(15) == 0) rl[b] = 1'b1;
      s = 1'($urandom_range(1));
      l = ($urandom_range(9) == 0);
      drive(r, rl, s, l);
      tick();
      exp_err = 0;
      if (owner >= 0) begin
        if (s) ph = (ph + 1) % 4;
        if (rl[2'(owner)] || !r[2'(owner)]) begin
          ptr = (owner + 1) % 4; owner = -1; cool = 1;
        end else if (age == HOLD_MAX - 1) begin
          ptr = (owner + 1) % 4; owner = -1; cool = 1; exp_err = 1;
        end else begin
          age++;
        end
      end else if (cool) begin
        cool = 0;
      end else if (arb) begin
        arb = 0;
        if (r != 4'b0 && !l) begin
          for (int k = 3; k >= 0; k--) begin
            cand = (ptr + k) % 4;
            if (r[2'(cand)]) owner = cand;
          end
          age = 0;
        end
      end else if (r != 4'b0 && !l) begin
        arb = 1;
      end
      exp_gnt  = (owner >= 0) ? (4'b0001 << owner) : 4'b0;
      exp_busy = (owner >= 0) || arb || cool;
      checks++;
      if (bus.gnt !== exp_gnt) begin
        errors++;
        $display("FAIL rand_gnt cycle=%0d gnt=%b expected %b", c, bus.gnt, exp_gnt);
      end
      checks++;
      if (bus.phase !== 2'(ph)) begin
        errors++;
        $display("FAIL rand_phase cycle=%0d phase=%0d expected %0d", c, bus.phase, ph);
      end
      checks++;
      if (bus.busy !== exp_busy) begin
        errors++;
        $display("FAIL rand_busy cycle=%0d busy=%b expected %b", c, bus.busy, exp_busy);
      end
      checks++;
      if (bus.err !== exp_err) begin
        errors++;
        $display("FAIL rand_err cycle=%0d err=%b expected %b", c, bus.err, exp_err);
      end
    end
  endtask

  initial begin
    drive(4'b0, 4'b0, 1'b0, 1'b0);
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_lock();
    test_abuse();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
